calc_display: RTL

Display-side receiver for the calculator's digit stream. Samples `status`/`data`/`pos` from the `calc` core, assembles an 8-digit frame in a shadow buffer, commits it atomically when the core reports ready, and time-multiplexes the committed frame onto eight common-anode seven-segment digits. It also renders the error and busy conditions. It sits between `calc` and the board pins.

---
 rtl/calc_pkg.sv | 46 ++++
 rtl/calc_display_if.sv | 20 ++
 rtl/seg7_encode.sv | 29 ++
 rtl/calc_display.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared status codes, FSM states and segment patterns for the display path
package calc_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [1:0] ST_ERRO  = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;
  localparam logic [1:0] ST_PRINT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_COMMIT,
    S_ERROR
  } disp_state_t;

  // Symbols 0..9 are BCD digits; the rest are glyphs that never come from the stream directly
  typedef logic [4:0] sym_t;
  localparam sym_t SYM_BLANK = 5'd16;
  localparam sym_t SYM_DASH  = 5'd17;
  localparam sym_t SYM_E     = 5'd18;
  localparam sym_t SYM_R     = 5'd19;
  localparam sym_t SYM_O     = 5'd20;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_O     = 7'h23;

  function automatic sym_t bcd_sym(input logic [3:0] d);
    return (d > 4'd9) ? SYM_DASH : {1'b0, d};
  endfunction

endpackage

// File: rtl/calc_display_if.sv
// rtl/calc_display_if.sv - digit stream from the calc core plus the board-side display pins
interface calc_display_if;
  logic [1:0] status;
  logic [3:0] data;
  logic [3:0] pos;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  modport master (
    output status, data, pos,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  status, data, pos,
    output an, seg, dp, frame_done
  );
endinterface

// File: rtl/seg7_encode.sv
// rtl/seg7_encode.sv - combinational symbol to active-low {g,f,e,d,c,b,a} pattern
module seg7_encode
  import calc_pkg::*;
(
  input  sym_t       i_sym,
  output logic [6:0] o_seg
);

  always_comb begin
    case (i_sym)
      5'd0:     o_seg = SEG_0;
      5'd1:     o_seg = SEG_1;
      5'd2:     o_seg = SEG_2;
      5'd3:     o_seg = SEG_3;
      5'd4:     o_seg = SEG_4;
      5'd5:     o_seg = SEG_5;
      5'd6:     o_seg = SEG_6;
      5'd7:     o_seg = SEG_7;
      5'd8:     o_seg = SEG_8;
      5'd9:     o_seg = SEG_9;
      SYM_DASH: o_seg = SEG_DASH;
      SYM_E:    o_seg = SEG_E;
      SYM_R:    o_seg = SEG_R;
      SYM_O:    o_seg = SEG_O;
      default:  o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/calc_display.sv
// rtl/calc_display.sv - captures the calc digit stream into a shadow frame, commits it atomically
// and multiplexes the visible frame onto eight common-anode seven-segment digits
module calc_display
  import calc_pkg::*;
#(
  parameter int SCAN_DIV    = 1000,
  parameter bit BLANK_ZEROS = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  calc_display_if.slave bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  disp_state_t                 r_state;
  logic [NUM_DIGITS-1:0][3:0]  r_shadow;
  logic [NUM_DIGITS-1:0][3:0]  r_visible;
  logic [NUM_DIGITS-1:0]       r_mask;
  logic                        r_frame_done;

  logic [DIV_W-1:0]            r_div;
  logic [2:0]                  r_scan;
  logic                        r_scan_on;
  logic [7:0]                  r_an;
  logic [6:0]                  r_seg;
  logic                        r_dp;

  logic                        w_sample_valid;
  logic [2:0]                  w_slot;
  logic [NUM_DIGITS-1:0]       w_slot_bit;
  logic [NUM_DIGITS-1:0]       w_lead_zero;
  sym_t                        w_sym;
  logic [6:0]                  w_seg;

  assign w_sample_valid = (bus.status == ST_PRINT) && (bus.pos >= 4'd1) && (bus.pos <= 4'd8);
  // pos 8 wraps through 3'b000 - 1 to slot 7, so the low three bits are enough
  assign w_slot         = bus.pos[2:0] - 3'd1;
  assign w_slot_bit     = w_sample_valid ? (NUM_DIGITS'(1) << w_slot) : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_shadow     <= '0;
      r_visible    <= '0;
      r_mask       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_sample_valid && (r_state != S_COMMIT)) begin
        r_shadow[w_slot] <= bus.data;
      end
      case (r_state)
        S_IDLE, S_ERROR: begin
          if (bus.status == ST_PRINT) begin
            r_state <= S_CAPTURE;
            r_mask  <= w_slot_bit;
          end
        end
        S_CAPTURE: begin
          case (bus.status)
            ST_PRINT: r_mask  <= r_mask | w_slot_bit;
            ST_READY: r_state <= (r_mask == '1) ? S_COMMIT : S_IDLE;
            ST_BUSY:  if (r_mask != '1) r_state <= S_IDLE;
            default:  ;
          endcase
        end
        S_COMMIT: begin
          r_visible    <= r_shadow;
          r_frame_done <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // Error status overrides whatever the case above chose
      if (bus.status == ST_ERRO) begin
        r_state <= S_ERROR;
      end
    end
  end

  always_comb begin
    w_lead_zero                 = '0;
    w_lead_zero[NUM_DIGITS-1]   = (r_visible[NUM_DIGITS-1] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      w_lead_zero[i] = w_lead_zero[i+1] && (r_visible[i] == 4'd0);
    end
  end

  always_comb begin
    w_sym = SYM_BLANK;
    if (r_state == S_ERROR) begin
      case (r_scan)
        3'd3:    w_sym = SYM_E;
        3'd2:    w_sym = SYM_R;
        3'd1:    w_sym = SYM_R;
        3'd0:    w_sym = SYM_O;
        default: w_sym = SYM_BLANK;
      endcase
    end else if (BLANK_ZEROS && (r_scan != 3'd0) && w_lead_zero[r_scan]) begin
      w_sym = SYM_BLANK;
    end else begin
      w_sym = bcd_sym(r_visible[r_scan]);
    end
  end

  seg7_encode u_seg7_encode (
    .i_sym (w_sym),
    .o_seg (w_seg)
  );

  // Digits stay dark until the first scan tick so exactly one anode is ever low afterwards
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_div     <= '0;
      r_scan    <= '0;
      r_scan_on <= 1'b0;
      r_an      <= 8'hFF;
      r_seg     <= SEG_BLANK;
      r_dp      <= 1'b1;
    end else begin
      if (r_div == DIV_W'(SCAN_DIV - 1)) begin
        r_div     <= '0;
        r_scan    <= r_scan + 3'd1;
        r_scan_on <= 1'b1;
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
      r_an  <= r_scan_on ? ~(8'd1 << r_scan) : 8'hFF;
      r_seg <= w_seg;
      r_dp  <= !(r_scan_on && (r_scan == 3'd0) && (bus.status == ST_BUSY) && (r_state != S_ERROR));
    end
  end

  assign bus.an         = r_an;
  assign bus.seg        = r_seg;
  assign bus.dp         = r_dp;
  assign bus.frame_done = r_frame_done;

endmodule
